reaction_timer_bcd: RTL

// - Consumes the 1-cycle tick strobe from the clock divider and measures elapsed ticks.
// - The start event is lights-out from the start-line sequencer; the stop event is the player button.
// - Result is a DIGITS-wide packed BCD count for the 7-segment display path.
// - Flags false starts (button before lights-out) and overflow.

---
 rtl/reaction_timer_bcd.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/reaction_timer_bcd.sv
// Reaction timer: counts divider ticks in packed BCD from lights-out to the
// player's button press, flagging false starts and saturation.
module reaction_timer_bcd #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_tick,
    input  logic                  i_arm,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_clear,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_running,
    output logic                  o_done,
    output logic                  o_false_start,
    output logic                  o_overflow,
    output logic                  o_valid
);

    localparam int unsigned W = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   bcd_q, bcd_d;
    logic           stop_q, stop_d;
    logic           false_start_q, false_start_d;
    logic           overflow_q, overflow_d;
    logic           running_q, running_d;
    logic           done_q, done_d;
    logic           done_dly_q, done_dly_d;
    logic           valid_q, valid_d;
    logic           stop_rise;
    logic           bcd_all9;

    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = 4'(v[4*i +: 4] + 4'd1);
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic all_nines(input logic [W-1:0] v);
        logic r;
        r = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9) r = 1'b0;
        end
        return r;
    endfunction

    assign stop_d    = i_stop;
    assign stop_rise = i_stop & ~stop_q;
    assign bcd_all9  = all_nines(bcd_q);

    // State and datapath registers; stop_q resets high so a held button is not an edge
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= S_IDLE;
            bcd_q         <= '0;
            stop_q        <= 1'b1;
            false_start_q <= 1'b0;
            overflow_q    <= 1'b0;
            running_q     <= 1'b0;
            done_q        <= 1'b0;
            done_dly_q    <= 1'b0;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            bcd_q         <= bcd_d;
            stop_q        <= stop_d;
            false_start_q <= false_start_d;
            overflow_q    <= overflow_d;
            running_q     <= running_d;
            done_q        <= done_d;
            done_dly_q    <= done_dly_d;
            valid_q       <= valid_d;
        end
    end

    // Next state; priority clear > stop edge > start > arm
    always_comb begin
        state_d = state_q;
        if (i_clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (i_arm) state_d = S_ARMED;
                S_ARMED: begin
                    if (stop_rise)    state_d = S_DONE;
                    else if (i_start) state_d = S_RUN;
                end
                S_RUN:   if (stop_rise || (i_tick && bcd_all9)) state_d = S_DONE;
                S_DONE:  if (i_arm) state_d = S_ARMED;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Count, sticky flags and status outputs
    always_comb begin
        bcd_d         = bcd_q;
        false_start_d = false_start_q;
        overflow_d    = overflow_q;
        if (i_clear) begin
            bcd_d         = '0;
            false_start_d = 1'b0;
            overflow_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (i_arm) begin
                        bcd_d         = '0;
                        false_start_d = 1'b0;
                        overflow_d    = 1'b0;
                    end
                end
                S_ARMED: begin
                    if (stop_rise) begin
                        false_start_d = 1'b1;
                        bcd_d         = '0;
                    end else if (i_start) begin
                        bcd_d = '0;
                    end
                end
                S_RUN: begin
                    if (i_tick) begin
                        if (bcd_all9) overflow_d = 1'b1;
                        else          bcd_d      = bcd_inc(bcd_q);
                    end
                end
                default: bcd_d = bcd_q;
            endcase
        end
        running_d  = (state_d == S_RUN);
        done_d     = (state_d == S_DONE);
        done_dly_d = done_q;
        valid_d    = done_q & ~done_dly_q;
    end

    assign o_bcd         = bcd_q;
    assign o_running     = running_q;
    assign o_done        = done_q;
    assign o_false_start = false_start_q;
    assign o_overflow    = overflow_q;
    assign o_valid       = valid_q;

endmodule
